// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 64-bit ALU: accepts a request, decodes {class, funct} into ALUOp,
// holds registered operands for EXEC_CYCLES cycles, captures Result/ZERO and returns them.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_class,
    input  logic [3:0]       i_req_funct,
    input  logic [WIDTH-1:0] i_req_a,
    input  logic [WIDTH-1:0] i_req_b,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_zero,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_zero,
    output logic             o_rsp_taken,
    output logic             o_rsp_illegal,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [3:0] ExecInit = 4'(EXEC_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [3:0]       r_cnt;
    logic [1:0]       r_class;
    logic             r_illegal;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_taken;
    logic             r_rsp_illegal;
    logic [CNT_W-1:0] r_op_count;

    logic [3:0]       w_dec_op;
    logic             w_dec_illegal;
    logic             w_accept;
    logic             w_capture;
    logic             w_release;

    assign w_accept  = (r_state == StIdle) && i_req_valid;
    assign w_capture = (r_state == StExec) && (r_cnt == 4'd0);
    assign w_release = (r_state == StResp) && i_rsp_ready;

    // funct is only meaningful for R-type; undefined R-type functs map to 1111 and flag illegal
    always_comb begin
        w_dec_op      = 4'b0010;
        w_dec_illegal = 1'b0;
        case (i_req_class)
            2'b00: w_dec_op = 4'b0010;
            2'b01: w_dec_op = 4'b0110;
            2'b11: w_dec_op = 4'b1100;
            default: begin
                case (i_req_funct)
                    4'b0000: w_dec_op = 4'b0010;
                    4'b1000: w_dec_op = 4'b0110;
                    4'b0111: w_dec_op = 4'b0000;
                    4'b0110: w_dec_op = 4'b0001;
                    default: begin
                        w_dec_op      = 4'b1111;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_req_valid) w_state_next = StExec;
            StExec:  if (r_cnt == 4'd0) w_state_next = StResp;
            StResp:  if (i_rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            StIdle:  o_req_ready = 1'b1;
            StResp:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt         <= 4'd0;
            r_class       <= 2'b00;
            r_illegal     <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= 4'b0000;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_op_count    <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= i_req_a;
                r_alu_b   <= i_req_b;
                r_alu_op  <= w_dec_op;
                r_class   <= i_req_class;
                r_illegal <= w_dec_illegal;
                r_cnt     <= ExecInit;
            end else if ((r_state == StExec) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result  <= i_alu_result;
                r_rsp_zero    <= i_alu_zero;
                r_rsp_taken   <= (r_class == 2'b01) && i_alu_zero;
                r_rsp_illegal <= r_illegal;
            end
            if (w_release) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign o_rsp_result  = r_rsp_result;
    assign o_rsp_zero    = r_rsp_zero;
    assign o_rsp_taken   = r_rsp_taken;
    assign o_rsp_illegal = r_rsp_illegal;
    assign o_op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1/CNT_W=16, one with
// EXEC_CYCLES=3/CNT_W=4 so the counter wrap is reachable. A behavioural ALU closes the loop.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  req_class;
    logic [3:0]  req_funct;
    logic [63:0] req_a;
    logic [63:0] req_b;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0;
    logic [63:0] alu_a0, alu_b0, alu_result0, rsp_result0;
    logic [3:0]  alu_op0;
    logic        alu_zero0, rsp_zero0, rsp_taken0, rsp_illegal0;
    logic [15:0] op_count0;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1;
    logic [63:0] alu_a1, alu_b1, alu_result1, rsp_result1;
    logic [3:0]  alu_op1;
    logic        alu_zero1, rsp_zero1, rsp_taken1, rsp_illegal1;
    logic [3:0]  op_count1;

    int n_cmp = 0;
    int n_err = 0;
    int e_cnt = 0;
    int cyc;

    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1100: return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    assign alu_result0 = alu_f(alu_op0, alu_a0, alu_b0);
    assign alu_zero0   = (alu_result0 == 64'd0);
    assign alu_result1 = alu_f(alu_op1, alu_a1, alu_b1);
    assign alu_zero1   = (alu_result1 == 64'd0);

    alu_issue_ctrl #(.WIDTH(64), .EXEC_CYCLES(1), .CNT_W(16)) u_dut0 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_class(req_class), .i_req_funct(req_funct),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_alu_a(alu_a0), .o_alu_b(alu_b0), .o_alu_op(alu_op0),
        .i_alu_result(alu_result0), .i_alu_zero(alu_zero0),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
        .o_rsp_result(rsp_result0), .o_rsp_zero(rsp_zero0),
        .o_rsp_taken(rsp_taken0), .o_rsp_illegal(rsp_illegal0),
        .o_op_count(op_count0)
    );

    alu_issue_ctrl #(.WIDTH(64), .EXEC_CYCLES(3), .CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid1), .o_req_ready(req_ready1),
        .i_req_class(req_class), .i_req_funct(req_funct),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_alu_a(alu_a1), .o_alu_b(alu_b1), .o_alu_op(alu_op1),
        .i_alu_result(alu_result1), .i_alu_zero(alu_zero1),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1),
        .o_rsp_result(rsp_result1), .o_rsp_zero(rsp_zero1),
        .o_rsp_taken(rsp_taken1), .o_rsp_illegal(rsp_illegal1),
        .o_op_count(op_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the EXEC_CYCLES=1 instance with rsp_ready asserted in RESP
    task automatic do_op(input string tag, input logic [1:0] cls, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] e_op,
                         input logic [63:0] e_res, input logic e_zero, input logic e_taken,
                         input logic e_ill);
        chk({tag, ".ready"}, 64'(req_ready0), 64'd1);
        req_class  = cls;
        req_funct  = fn;
        req_a      = a;
        req_b      = b;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        chk({tag, ".op"}, 64'(alu_op0), 64'(e_op));
        chk({tag, ".exec_valid"}, 64'(rsp_valid0), 64'd0);
        step();
        chk({tag, ".valid"}, 64'(rsp_valid0), 64'd1);
        chk({tag, ".result"}, rsp_result0, e_res);
        chk({tag, ".zero"}, 64'(rsp_zero0), 64'(e_zero));
        chk({tag, ".taken"}, 64'(rsp_taken0), 64'(e_taken));
        chk({tag, ".illegal"}, 64'(rsp_illegal0), 64'(e_ill));
        rsp_ready0 = 1'b1;
        step();
        rsp_ready0 = 1'b0;
        e_cnt++;
        chk({tag, ".count"}, 64'(op_count0), 64'(e_cnt));
        chk({tag, ".hold_a"}, alu_a0, a);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        req_class  = 2'b00;
        req_funct  = 4'b0000;
        req_a      = 64'd0;
        req_b      = 64'd0;
        req_valid0 = 1'b0;
        rsp_ready0 = 1'b0;
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;
        step();
        step();
        chk("rst.req_ready", 64'(req_ready0), 64'd1);
        chk("rst.rsp_valid", 64'(rsp_valid0), 64'd0);
        chk("rst.alu_op", 64'(alu_op0), 64'd0);
        chk("rst.op_count", 64'(op_count0), 64'd0);
        reset = 1'b0;
        step();

        do_op("add", 2'b00, 4'b0000, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0, 1'b0);
        do_op("beq_t", 2'b01, 4'b0000, 64'hDEAD, 64'hDEAD, 4'b0110, 64'd0, 1'b1, 1'b1, 1'b0);
        do_op("beq_n", 2'b01, 4'b0000, 64'd3, 64'd2, 4'b0110, 64'd1, 1'b0, 1'b0, 1'b0);
        do_op("and", 2'b10, 4'b0111, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0, 1'b0, 1'b0);
        do_op("or", 2'b10, 4'b0110, 64'hF0, 64'h3C, 4'b0001, 64'hFC, 1'b0, 1'b0, 1'b0);
        do_op("illegal", 2'b10, 4'b0101, 64'hF0, 64'h3C, 4'b1111, 64'd0, 1'b1, 1'b0, 1'b1);
        do_op("nor", 2'b11, 4'b0000, 64'd0, 64'd0, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              1'b0, 1'b0);
        do_op("radd", 2'b10, 4'b0000, 64'd1, 64'd2, 4'b0010, 64'd3, 1'b0, 1'b0, 1'b0);
        do_op("rsub", 2'b10, 4'b1000, 64'd5, 64'd5, 4'b0110, 64'd0, 1'b1, 1'b0, 1'b0);
        do_op("ls_fn", 2'b00, 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1,
              1'b0, 1'b0);

        // Backpressure: response held while requester keeps valid high with new operands
        req_class  = 2'b00;
        req_funct  = 4'b0000;
        req_a      = 64'd1;
        req_b      = 64'd1;
        req_valid0 = 1'b1;
        step();
        chk("bp.alu_a", alu_a0, 64'd1);
        req_a = 64'd10;
        req_b = 64'd20;
        step();
        chk("bp.valid", 64'(rsp_valid0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_valid", 64'(rsp_valid0), 64'd1);
            chk("bp.hold_result", rsp_result0, 64'd2);
            chk("bp.hold_ready", 64'(req_ready0), 64'd0);
            chk("bp.hold_count", 64'(op_count0), 64'(e_cnt));
            chk("bp.hold_alu_a", alu_a0, 64'd1);
        end
        rsp_ready0 = 1'b1;
        step();
        e_cnt++;
        chk("bp.rel_count", 64'(op_count0), 64'(e_cnt));
        chk("bp.rel_ready", 64'(req_ready0), 64'd1);
        chk("bp.rel_valid", 64'(rsp_valid0), 64'd0);
        step();
        req_valid0 = 1'b0;
        chk("bp.next_ready", 64'(req_ready0), 64'd0);
        chk("bp.next_alu_a", alu_a0, 64'd10);
        step();
        chk("bp.next_valid", 64'(rsp_valid0), 64'd1);
        chk("bp.next_result", rsp_result0, 64'd30);
        step();
        rsp_ready0 = 1'b0;
        e_cnt++;
        chk("bp.next_count", 64'(op_count0), 64'(e_cnt));

        // EXEC_CYCLES=3 instance: latency, throughput and 4-bit counter wrap
        rsp_ready1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req_class  = 2'b00;
            req_a      = 64'(k);
            req_b      = 64'd100;
            req_valid1 = 1'b1;
            step();
            req_valid1 = 1'b0;
            cyc = 0;
            while (!rsp_valid1 && cyc < 10) begin
                step();
                cyc++;
            end
            chk("x3.latency", 64'(cyc), 64'd3);
            chk("x3.result", rsp_result1, 64'(k + 100));
            step();
            chk("x3.count", 64'(op_count1), 64'((k + 1) % 16));
        end
        chk("x3.ready_after_wrap", 64'(req_ready1), 64'd1);

        // Reset while the slow instance is in EXEC drops the operation
        req_a      = 64'd9;
        req_b      = 64'd9;
        req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        step();
        chk("mid.in_exec", 64'(req_ready1), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid.req_ready", 64'(req_ready1), 64'd1);
        chk("mid.rsp_valid", 64'(rsp_valid1), 64'd0);
        chk("mid.alu_a", alu_a1, 64'd0);
        chk("mid.alu_op", 64'(alu_op1), 64'd0);
        chk("mid.rsp_result", rsp_result1, 64'd0);
        chk("mid.d0_count", 64'(op_count0), 64'd0);
        chk("mid.d0_alu_a", alu_a0, 64'd0);
        chk("mid.d0_alu_op", 64'(alu_op0), 64'd0);
        chk("mid.d0_result", rsp_result0, 64'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid.no_rsp", 64'(rsp_valid1), 64'd0);
        chk("mid.idle", 64'(req_ready1), 64'd1);
        chk("mid.count", 64'(op_count1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
